// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the nibble-serial adder: the datapath slice width and
// the controller state encoding.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // Width of one datapath slice processed per RUN cycle.
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_nibble_adder4.sv
// -----------------------------------------------------------------------------
// nibble_adder4
// Purely combinational 4-bit ripple-carry adder used as the per-cycle slice of
// the serial adder.
//
// Ports:
//   a[3:0], b[3:0] : addend nibbles
//   cin            : carry into bit 0
//   sum[3:0]       : (a + b + cin) mod 16
//   cout           : carry out of bit 3
// -----------------------------------------------------------------------------
module nibble_adder4
    import serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // carry[i] is the carry into bit i; carry[NIBBLE_W] is the nibble carry out.
    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    // NOTE: every net here is a continuous assign with no feedback, so no
    // storage can be inferred from this adder.
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIBBLE_W];

endmodule : nibble_adder4

// File: rtl/serial_adder_16.sv
// -----------------------------------------------------------------------------
// serial_adder_16
// Nibble-serial adder: computes a + b + cin one 4-bit slice per clock, least
// significant nibble first, and holds the result until it is consumed.
//
// Parameters:
//   NIBBLES     : nibbles per operand (1..16); operand width W = 4*NIBBLES
//
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   start_valid : a, b, cin valid          start_ready : idle, can accept
//   a, b        : W-bit addends            cin         : carry in
//   done_valid  : sum/cout valid           done_ready  : downstream consumes
//   sum         : (a+b+cin) mod 2^W        cout        : carry out of bit W-1
//   busy        : high while in RUN
// -----------------------------------------------------------------------------
module serial_adder_16
    import serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        done_valid,
    input  logic                        done_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        busy
);

    localparam int              W     = NIBBLE_W * NIBBLES;
    localparam int              CNT_W = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    nibble_adder4 u_nibble_adder4 (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // NOTE: all registers use non-blocking assignments so every branch reads
    // the pre-edge values, matching the hardware flop behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these are a handful of flops, not a memory array, so clearing
            // them all on reset is cheap and keeps a discarded result invisible.
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    // New nibble enters at the MSB end; after NIBBLES shifts the
                    // first (least significant) nibble has reached bit 0.
                    sum_q   <= (sum_q >> NIBBLE_W) | (W'(nib_sum) << (W - NIBBLE_W));
                    carry_q <= nib_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    // Returning to IDLE here (rather than accepting directly)
                    // guarantees one idle cycle between results.
                    if (done_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state == RUN);
    assign done_valid  = (state == DONE);
    assign sum         = sum_q;
    assign cout        = carry_q;

endmodule : serial_adder_16

// File: doc/serial_adder_16.md
SERIAL_ADDER_16 -- requirements
Module: serial_adder_16

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start_valid, input, 1 bit: operands on a, b and cin are valid.
REQ-005 SHALL have port start_ready, output, 1 bit: block can accept an operand set.
REQ-006 SHALL have port a, input, W bits: addend A.
REQ-007 SHALL have port b, input, W bits: addend B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in.
REQ-009 SHALL have port done_valid, output, 1 bit: sum and cout are valid.
REQ-010 SHALL have port done_ready, input, 1 bit: downstream consumes the result.
REQ-011 SHALL have port sum, output, W bits: result a+b+cin mod 2^W.
REQ-012 SHALL have port cout, output, 1 bit: carry out of bit W-1.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive start_ready = (state==IDLE), done_valid = (state==DONE) and busy = (state==RUN), all decoded combinationally from the state register.
REQ-016 SHALL, on accept (start_valid && start_ready at a clock edge), capture a and b into shift registers, load the carry register with cin, clear the nibble counter, and enter RUN.
REQ-017 SHALL, in each RUN cycle: add the low nibbles of A, B and the carry register in one 4-bit combinational adder; shift the 4-bit result into sum from the MSB end; shift A and B right by 4; load carry with the nibble carry; increment the counter.
REQ-018 SHALL leave RUN for DONE on the edge that processes nibble NIBBLES-1.
REQ-019 SHALL make done_valid high exactly NIBBLES cycles after the accept edge; for NIBBLES=4 the latency is 4 cycles.
REQ-020 SHALL drive cout from the final carry register value.
REQ-021 SHALL hold sum and cout stable in DONE until done_valid && done_ready, then return to IDLE on that edge.
REQ-022 SHALL ignore start_valid in RUN and DONE (start_ready low; no capture, no corruption).
REQ-023 SHALL NOT accept a new operand set on the same edge the result is consumed; the minimum accept-to-accept spacing is NIBBLES+2 cycles.
REQ-024 SHALL consider a, b and cin only on the accept edge; changes at any other time have no effect.
REQ-025 SHALL produce sum and cout bit-exact to (a+b+cin) for all inputs, including the all-ones + all-ones + 1 case.

Reset
REQ-026 SHALL, on an edge with rst high, enter IDLE, clear sum, cout, the carry register, the counter and the operand registers, giving start_ready=1, done_valid=0 and busy=0.
REQ-027 SHALL let rst take priority over every other input, including mid-RUN and in DONE; a partial result is discarded and never presented.
REQ-028 SHALL accept a new operand set on the first edge after rst deasserts if start_valid is high.

Structure
REQ-029 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE_W=4 in the shared package serial_adder_pkg.
REQ-030 SHALL contain exactly one sub-module, nibble_adder4: a purely combinational 4-bit ripple adder with ports a[3:0], b[3:0], cin, sum[3:0] and cout.
REQ-031 SHALL keep the counter width at clog2(NIBBLES)+1 bits.

Verification (NIBBLES=4)
REQ-032 SHALL cover: a=16'h1234, b=16'h4321, cin=0 -> done_valid high 4 cycles after accept, sum=16'h5555, cout=0.
REQ-033 SHALL cover: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (full carry ripple across nibbles).
REQ-034 SHALL cover: a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-035 SHALL cover: done_ready held low for 10 cycles after done_valid, with start_valid pulsed and a, b toggled -> sum and cout unchanged, start_ready stays 0, and a single IDLE return after done_ready goes high.
REQ-036 SHALL cover: rst asserted on the 2nd RUN cycle of 16'h8000+16'h8000 -> next cycle IDLE, sum=0, cout=0, no done_valid; a following 16'h0001+16'h0002 yields 16'h0003, cout=0.
REQ-037 SHALL cover: 200 random operand sets with random done_ready stalls -> every result matches a reference model, with no lost or duplicated results.
